// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit: datapath width,
// operation and state encodings, divide-by-zero result constants and a small
// helper that turns a possibly-signed operand into its unsigned magnitude.
// ---------------------------------------------------------------------------
package mdu_pkg;

    localparam int WORD_W = 32;

    // Operation codes as presented on the op port.
    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_t;

    // Divisor value that triggers the shortcut path and the LO value it yields.
    localparam logic [WORD_W-1:0] DIV_ZERO_DIVISOR = '0;
    localparam logic [WORD_W-1:0] DIV_ZERO_LO      = '1;

    // Magnitude of an operand. For signed ops the most negative value maps to
    // 2^(WORD_W-1), which is still representable as an unsigned word.
    function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] value,
                                                    input logic              is_signed);
        if (is_signed && value[WORD_W-1])
            return -value;
        return value;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// ---------------------------------------------------------------------------
// mdu_if
// Port bundle for mult_div_unit. The clock stays outside the bundle so the
// same interface can be wired to any clock domain source.
//   modport mdu : unit side (consumes controls/operands, drives results)
//   modport tb  : testbench/pipeline side (drives controls, observes results)
// ---------------------------------------------------------------------------
interface mdu_if;
    import mdu_pkg::*;

    logic              RST;
    logic              start;
    logic [1:0]        op;
    logic [WORD_W-1:0] port_a;
    logic [WORD_W-1:0] port_b;
    logic              wr_hi;
    logic              wr_lo;
    logic              flush;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [WORD_W-1:0] hi;
    logic [WORD_W-1:0] lo;

    modport mdu (
        input  RST, start, op, port_a, port_b, wr_hi, wr_lo, flush,
        output busy, done, div_zero, hi, lo
    );

    modport tb (
        output RST, start, op, port_a, port_b, wr_hi, wr_lo, flush,
        input  busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/mdu_step.sv
// ---------------------------------------------------------------------------
// mdu_step
// One combinational iteration of the multiply/divide datapath.
//   op      : operation in flight (only multiply vs divide matters here)
//   acc_hi  : upper accumulator half (partial product / partial remainder)
//   acc_lo  : lower accumulator half (multiplier bits / dividend-quotient)
//   operand : multiplicand magnitude or divisor magnitude
//   nxt_hi  : upper accumulator after this step
//   nxt_lo  : lower accumulator after this step
// ---------------------------------------------------------------------------
module mdu_step #(
    parameter int WORD_W = 32
) (
    input  mdu_pkg::mdu_op_t op,
    input  logic [WORD_W-1:0] acc_hi,
    input  logic [WORD_W-1:0] acc_lo,
    input  logic [WORD_W-1:0] operand,
    output logic [WORD_W-1:0] nxt_hi,
    output logic [WORD_W-1:0] nxt_lo
);
    import mdu_pkg::*;

    logic            is_div;
    logic [WORD_W:0] mul_sum;
    logic [WORD_W:0] div_shifted;
    logic [WORD_W:0] div_diff;
    logic            div_fits;

    assign is_div = (op == DIV) || (op == DIVU);

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole 64-bit accumulator right, keeping the add's carry.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);

    // Divide: shift the next dividend bit into the partial remainder and try
    // subtracting the divisor. The partial remainder is always below the
    // divisor, so the top bit of the difference is a clean borrow indicator.
    assign div_shifted = {acc_hi, acc_lo[WORD_W-1]};
    assign div_diff    = div_shifted - {1'b0, operand};
    assign div_fits    = ~div_diff[WORD_W];

    always_comb begin
        nxt_hi = '0;
        nxt_lo = '0;
        if (is_div) begin
            nxt_hi = div_fits ? div_diff[WORD_W-1:0] : div_shifted[WORD_W-1:0];
            nxt_lo = {acc_lo[WORD_W-2:0], div_fits};
        end else begin
            nxt_hi = mul_sum[WORD_W:1];
            nxt_lo = {mul_sum[0], acc_lo[WORD_W-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative 32-cycle multiply/divide unit with architectural HI/LO.
//   CLK, RST       : clock, asynchronous active-high reset
//   start, op      : launch MULT/MULTU/DIV/DIVU on port_a/port_b
//   port_a, port_b : rs/rt operands; port_a also carries MTHI/MTLO data
//   wr_hi, wr_lo   : MTHI/MTLO writes, honoured only when not busy
//   flush          : abort any in-flight operation, HI/LO untouched
//   busy           : operation in progress (RUN or FIX)
//   done           : one-cycle pulse after an operation wrote HI/LO
//   div_zero       : sticky, set when the last accepted op divided by zero
//   hi, lo         : HI and LO registers
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] port_a,
    input  logic [WORD_W-1:0] port_b,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);
    import mdu_pkg::*;

    mdu_state_t          state;
    mdu_state_t          next_state;
    logic [4:0]          count;
    mdu_op_t             op_q;
    logic [WORD_W-1:0]   acc_hi;
    logic [WORD_W-1:0]   acc_lo;
    logic [WORD_W-1:0]   operand;
    logic                neg_lo;
    logic                neg_hi;

    logic                can_launch;
    logic                accept;
    logic                launch_div;
    logic                launch_dz;
    logic                launch_signed;
    logic [WORD_W-1:0]   a_mag;
    logic [WORD_W-1:0]   b_mag;
    logic                wr_ok;

    logic [WORD_W-1:0]   step_hi;
    logic [WORD_W-1:0]   step_lo;

    logic [2*WORD_W-1:0] product;
    logic [2*WORD_W-1:0] product_fix;
    logic [WORD_W-1:0]   fix_hi;
    logic [WORD_W-1:0]   fix_lo;

    // Launch decode. A start is taken only between operations and never in
    // the same cycle as a flush.
    assign can_launch    = (state == IDLE) || (state == DONE);
    assign accept        = can_launch && start && !flush;
    assign launch_div    = op[1];
    assign launch_signed = !op[0];
    assign launch_dz     = launch_div && (port_b == DIV_ZERO_DIVISOR);
    assign a_mag         = magnitude(port_a, launch_signed);
    assign b_mag         = magnitude(port_b, launch_signed);

    // MTHI/MTLO are only honoured between operations, and a simultaneous
    // start takes priority over them.
    assign wr_ok = can_launch && !start;

    mdu_step #(.WORD_W(WORD_W)) u_step (
        .op      (op_q),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    // Sign fix-up. Multiplies negate the full 64-bit product; divides negate
    // quotient and remainder independently. The divide-by-zero path preloads
    // its final result with both negate flags clear, so it passes through.
    assign product     = {acc_hi, acc_lo};
    assign product_fix = neg_lo ? -product : product;

    always_comb begin
        fix_hi = product_fix[2*WORD_W-1:WORD_W];
        fix_lo = product_fix[WORD_W-1:0];
        if ((op_q == DIV) || (op_q == DIVU)) begin
            fix_hi = neg_hi ? -acc_hi : acc_hi;
            fix_lo = neg_lo ? -acc_lo : acc_lo;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic. Flush overrides everything, including a start.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start)
                        next_state = launch_dz ? FIX : RUN;
                    else
                        next_state = IDLE;
                end
                RUN:     next_state = (count == 5'd31) ? FIX : RUN;
                FIX:     next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs decoded straight from the state register, so they are glitch
    // free and change only on clock edges or reset.
    always_comb begin
        busy = (state == RUN) || (state == FIX);
        done = (state == DONE);
    end

    // Operand latch and iteration datapath. A divide by zero loads the final
    // HI/LO pattern directly so FIX can write it without special casing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q    <= MULT;
            count   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
        end else if (accept) begin
            op_q  <= mdu_op_t'(op);
            count <= '0;
            if (launch_dz) begin
                acc_hi  <= port_a;
                acc_lo  <= DIV_ZERO_LO;
                operand <= '0;
                neg_lo  <= 1'b0;
                neg_hi  <= 1'b0;
            end else if (launch_div) begin
                acc_hi  <= '0;
                acc_lo  <= a_mag;
                operand <= b_mag;
                neg_lo  <= launch_signed && (port_a[WORD_W-1] ^ port_b[WORD_W-1]);
                neg_hi  <= launch_signed && port_a[WORD_W-1];
            end else begin
                acc_hi  <= '0;
                acc_lo  <= b_mag;
                operand <= a_mag;
                neg_lo  <= launch_signed && (port_a[WORD_W-1] ^ port_b[WORD_W-1]);
                neg_hi  <= 1'b0;
            end
        end else if ((state == RUN) && !flush) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count + 5'd1;
        end
    end

    // HI/LO registers: written by a completing operation or by MTHI/MTLO.
    // A flush in FIX drops the operation's write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hi <= '0;
            lo <= '0;
        end else if ((state == FIX) && !flush) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else if (wr_ok) begin
            if (wr_hi)
                hi <= port_a;
            if (wr_lo)
                lo <= port_a;
        end
    end

    // Divide-by-zero flag follows every accepted launch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            div_zero <= 1'b0;
        else if (accept)
            div_zero <= launch_dz;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Directed self-checking bench for mult_div_unit. Each scenario task drives
// its own stimulus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    logic clk;
    int   passed;
    int   total;

    mdu_if bus ();

    mult_div_unit #(.WORD_W(32)) dut (
        .CLK      (clk),
        .RST      (bus.RST),
        .start    (bus.start),
        .op       (bus.op),
        .port_a   (bus.port_a),
        .port_b   (bus.port_b),
        .wr_hi    (bus.wr_hi),
        .wr_lo    (bus.wr_lo),
        .flush    (bus.flush),
        .busy     (bus.busy),
        .done     (bus.done),
        .div_zero (bus.div_zero),
        .hi       (bus.hi),
        .lo       (bus.lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for exactly one edge (edge 0 of the operation).
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.op     = o;
        bus.port_a = a;
        bus.port_b = b;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
    endtask

    // Count edges after edge 0 until done shows up, bounded.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && edges < 100) begin
            if (bus.busy === 1'b1)
                busy_cycles++;
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        bus.RST = 1'b1;
        step();
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done); else passed++;
        total++; if (bus.div_zero !== 1'b0) $display("[TB] FAIL reset_div_zero: got %b expected 0", bus.div_zero); else passed++;
        total++; if (bus.hi !== 32'h0) $display("[TB] FAIL reset_hi: got %h expected 00000000", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0) $display("[TB] FAIL reset_lo: got %h expected 00000000", bus.lo); else passed++;
        bus.RST = 1'b0;
        step();
    endtask

    task automatic test_multu_max();
        int edges, busy_cycles;
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(edges, busy_cycles);
        total++; if (edges !== 33) $display("[TB] FAIL multu_latency: got %0d expected 33", edges); else passed++;
        total++; if (busy_cycles !== 33) $display("[TB] FAIL multu_busy_cycles: got %0d expected 33", busy_cycles); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFE) $display("[TB] FAIL multu_hi: got %h expected fffffffe", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0000_0001) $display("[TB] FAIL multu_lo: got %h expected 00000001", bus.lo); else passed++;
        step();
        total++; if (bus.done !== 1'b0) $display("[TB] FAIL multu_done_pulse: got %b expected 0", bus.done); else passed++;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL multu_idle_busy: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_mult_signed();
        int edges, busy_cycles;
        launch(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_done(edges, busy_cycles);
        total++; if (bus.hi !== 32'h4000_0000) $display("[TB] FAIL mult_min_hi: got %h expected 40000000", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0) $display("[TB] FAIL mult_min_lo: got %h expected 00000000", bus.lo); else passed++;
        launch(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(edges, busy_cycles);
        total++; if (bus.hi !== 32'hFFFF_FFFF) $display("[TB] FAIL mult_neg_hi: got %h expected ffffffff", bus.hi); else passed++;
        total++; if (bus.lo !== 32'hFFFF_FFEB) $display("[TB] FAIL mult_neg_lo: got %h expected ffffffeb", bus.lo); else passed++;
        step();
    endtask

    task automatic test_divide();
        int edges, busy_cycles;
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges, busy_cycles);
        total++; if (edges !== 33) $display("[TB] FAIL div_latency: got %0d expected 33", edges); else passed++;
        total++; if (bus.lo !== 32'hFFFF_FFFD) $display("[TB] FAIL div_neg_lo: got %h expected fffffffd", bus.lo); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFF) $display("[TB] FAIL div_neg_hi: got %h expected ffffffff", bus.hi); else passed++;
        launch(2'b11, 32'd100, 32'd7);
        wait_done(edges, busy_cycles);
        total++; if (bus.lo !== 32'd14) $display("[TB] FAIL divu_lo: got %h expected 0000000e", bus.lo); else passed++;
        total++; if (bus.hi !== 32'd2) $display("[TB] FAIL divu_hi: got %h expected 00000002", bus.hi); else passed++;
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges, busy_cycles);
        total++; if (bus.lo !== 32'h8000_0000) $display("[TB] FAIL div_min_lo: got %h expected 80000000", bus.lo); else passed++;
        total++; if (bus.hi !== 32'h0) $display("[TB] FAIL div_min_hi: got %h expected 00000000", bus.hi); else passed++;
        total++; if (bus.div_zero !== 1'b0) $display("[TB] FAIL div_min_dz: got %b expected 0", bus.div_zero); else passed++;
        step();
    endtask

    task automatic test_div_zero();
        int edges, busy_cycles;
        launch(2'b10, 32'd5, 32'd0);
        wait_done(edges, busy_cycles);
        total++; if (edges !== 1) $display("[TB] FAIL dz_latency: got %0d expected 1", edges); else passed++;
        total++; if (busy_cycles !== 1) $display("[TB] FAIL dz_busy_cycles: got %0d expected 1", busy_cycles); else passed++;
        total++; if (bus.lo !== 32'hFFFF_FFFF) $display("[TB] FAIL dz_lo: got %h expected ffffffff", bus.lo); else passed++;
        total++; if (bus.hi !== 32'd5) $display("[TB] FAIL dz_hi: got %h expected 00000005", bus.hi); else passed++;
        total++; if (bus.div_zero !== 1'b1) $display("[TB] FAIL dz_flag_set: got %b expected 1", bus.div_zero); else passed++;
        step();
        launch(2'b01, 32'd3, 32'd4);
        total++; if (bus.div_zero !== 1'b0) $display("[TB] FAIL dz_flag_clear: got %b expected 0", bus.div_zero); else passed++;
        wait_done(edges, busy_cycles);
        total++; if (bus.lo !== 32'd12) $display("[TB] FAIL dz_next_lo: got %h expected 0000000c", bus.lo); else passed++;
        step();
    endtask

    task automatic test_flush();
        int done_seen;
        done_seen = 0;
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL flush_busy: got %b expected 0", bus.busy); else passed++;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1)
                done_seen++;
            step();
        end
        total++; if (done_seen !== 0) $display("[TB] FAIL flush_no_done: got %0d expected 0", done_seen); else passed++;
        total++; if (bus.hi !== 32'h0) $display("[TB] FAIL flush_hi: got %h expected 00000000", bus.hi); else passed++;
        total++; if (bus.lo !== 32'd12) $display("[TB] FAIL flush_lo: got %h expected 0000000c", bus.lo); else passed++;
    endtask

    task automatic test_handshake();
        int edges, busy_cycles;
        launch(2'b11, 32'd100, 32'd7);
        repeat (4) step();
        bus.wr_hi  = 1'b1;
        bus.port_a = 32'h0000_1234;
        step();
        bus.wr_hi  = 1'b0;
        total++; if (bus.hi !== 32'h0) $display("[TB] FAIL busy_wr_hi_ignored: got %h expected 00000000", bus.hi); else passed++;
        bus.op     = 2'b01;
        bus.port_a = 32'd3;
        bus.port_b = 32'd3;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        total++; if (bus.busy !== 1'b1) $display("[TB] FAIL run_start_busy: got %b expected 1", bus.busy); else passed++;
        wait_done(edges, busy_cycles);
        total++; if (edges !== 27) $display("[TB] FAIL run_start_latency: got %0d expected 27", edges); else passed++;
        total++; if (bus.lo !== 32'd14) $display("[TB] FAIL run_start_lo: got %h expected 0000000e", bus.lo); else passed++;
        total++; if (bus.hi !== 32'd2) $display("[TB] FAIL run_start_hi: got %h expected 00000002", bus.hi); else passed++;
        step();
        bus.wr_hi  = 1'b1;
        bus.port_a = 32'h0000_1234;
        step();
        bus.wr_hi  = 1'b0;
        total++; if (bus.hi !== 32'h0000_1234) $display("[TB] FAIL idle_wr_hi: got %h expected 00001234", bus.hi); else passed++;
        total++; if (bus.lo !== 32'd14) $display("[TB] FAIL idle_wr_hi_lo_kept: got %h expected 0000000e", bus.lo); else passed++;
        bus.wr_hi  = 1'b1;
        bus.wr_lo  = 1'b1;
        bus.port_a = 32'h0000_BEEF;
        step();
        bus.wr_hi  = 1'b0;
        bus.wr_lo  = 1'b0;
        total++; if (bus.hi !== 32'h0000_BEEF) $display("[TB] FAIL both_wr_hi: got %h expected 0000beef", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0000_BEEF) $display("[TB] FAIL both_wr_lo: got %h expected 0000beef", bus.lo); else passed++;
        bus.wr_lo = 1'b1;
        launch(2'b01, 32'd3, 32'd4);
        bus.wr_lo = 1'b0;
        total++; if (bus.lo !== 32'h0000_BEEF) $display("[TB] FAIL start_beats_wr: got %h expected 0000beef", bus.lo); else passed++;
        wait_done(edges, busy_cycles);
        total++; if (bus.lo !== 32'd12) $display("[TB] FAIL start_beats_wr_result: got %h expected 0000000c", bus.lo); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        int edges, busy_cycles;
        launch(2'b11, 32'd100, 32'd7);
        wait_done(edges, busy_cycles);
        total++; if (bus.done !== 1'b1) $display("[TB] FAIL b2b_first_done: got %b expected 1", bus.done); else passed++;
        launch(2'b00, 32'hFFFF_FFFD, 32'd7);
        total++; if (bus.busy !== 1'b1) $display("[TB] FAIL b2b_no_gap: got %b expected 1", bus.busy); else passed++;
        total++; if (bus.lo !== 32'd14) $display("[TB] FAIL b2b_first_lo: got %h expected 0000000e", bus.lo); else passed++;
        wait_done(edges, busy_cycles);
        total++; if (edges !== 33) $display("[TB] FAIL b2b_latency: got %0d expected 33", edges); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFF) $display("[TB] FAIL b2b_hi: got %h expected ffffffff", bus.hi); else passed++;
        total++; if (bus.lo !== 32'hFFFF_FFEB) $display("[TB] FAIL b2b_lo: got %h expected ffffffeb", bus.lo); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        launch(2'b01, 32'd5, 32'd5);
        repeat (19) step();
        total++; if (bus.busy !== 1'b1) $display("[TB] FAIL rstmid_pre_busy: got %b expected 1", bus.busy); else passed++;
        bus.RST = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("[TB] FAIL rstmid_done: got %b expected 0", bus.done); else passed++;
        total++; if (bus.div_zero !== 1'b0) $display("[TB] FAIL rstmid_div_zero: got %b expected 0", bus.div_zero); else passed++;
        total++; if (bus.hi !== 32'h0) $display("[TB] FAIL rstmid_hi: got %h expected 00000000", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0) $display("[TB] FAIL rstmid_lo: got %h expected 00000000", bus.lo); else passed++;
        step();
        bus.RST = 1'b0;
        step();
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        bus.RST    = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.port_a = '0;
        bus.port_b = '0;
        bus.wr_hi  = 1'b0;
        bus.wr_lo  = 1'b0;
        bus.flush  = 1'b0;
        step();
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_divide();
        test_div_zero();
        test_flush();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
